// File: rtl/trace_pkg.sv
// Shared definitions for the retirement-trace capture buffer:
// FSM encoding, halt instruction value and the {pc, inst} entry layout.
package trace_pkg;

    localparam logic [1:0]  ST_CAPTURE = 2'd0;
    localparam logic [1:0]  ST_DRAIN   = 2'd1;
    localparam logic [1:0]  ST_DONE    = 2'd2;

    localparam logic [31:0] HALT_INST  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_entry_t;

    function automatic logic is_halt(input logic [31:0] inst);
        return (inst == HALT_INST);
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Sample-in / drain-out bundle of the trace buffer; slave is the buffer side,
// master is the CPU/consumer side.
interface cpu_trace_buffer_if #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
);
    logic                      trace_en;
    logic [31:0]               pc;
    logic [31:0]               inst;
    logic                      rd_ready;
    logic                      rd_valid;
    logic [31:0]               rd_pc;
    logic [31:0]               rd_inst;
    logic [$clog2(DEPTH):0]    count;
    logic                      halted;
    logic                      overflow;
    logic [CNT_W-1:0]          drop_cnt;
    logic                      done;

    modport slave (
        input  trace_en, pc, inst, rd_ready,
        output rd_valid, rd_pc, rd_inst, count, halted, overflow, drop_cnt, done
    );

    modport master (
        output trace_en, pc, inst, rd_ready,
        input  rd_valid, rd_pc, rd_inst, count, halted, overflow, drop_cnt, done
    );
endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries with an explicit occupancy
// register; the caller guarantees push is only raised when a slot is free.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t wdata,
    output trace_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    trace_entry_t    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // pointers wrap naturally at DEPTH; count tracks net push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // head entry, forced to zero while empty
    always_comb begin
        rdata = trace_entry_t'(64'h0);
        if (count_r != {CW{1'b0}}) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = trace_entry_t'(64'h0);
        end
    end

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures the CPU pc/inst pair each enabled clock, stops capturing at the
// halt instruction, and reports done once the captured trace has drained.
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    cpu_trace_buffer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]       state_r;
    logic             halted_r;
    logic             overflow_r;
    logic             done_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;
    logic             sample_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             halt_s;
    logic             drained_s;
    trace_entry_t     wdata_s;
    trace_entry_t     rdata_s;

    // a pop in the same edge frees the slot a full-FIFO push needs
    always_comb begin
        sample_s  = (state_r == ST_CAPTURE) & bus.trace_en;
        pop_s     = ~empty_s & bus.rd_ready;
        push_s    = sample_s & (~full_s | pop_s);
        drop_s    = sample_s & full_s & ~pop_s;
        halt_s    = sample_s & is_halt(bus.inst);
        drained_s = (count_s == CW'(0)) | ((count_s == CW'(1)) & pop_s);
        wdata_s   = '{pc: bus.pc, inst: bus.inst};
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // capture -> drain -> done sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CAPTURE;
        end else begin
            case (state_r)
                ST_CAPTURE: if (halt_s)    state_r <= ST_DRAIN;
                ST_DRAIN:   if (drained_s) state_r <= ST_DONE;
                ST_DONE:    state_r <= ST_DONE;
                default:    state_r <= ST_CAPTURE;
            endcase
        end
    end

    // sticky status and saturating drop counter (drops only occur while capturing)
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r   <= 1'b0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (halt_s) halted_r <= 1'b1;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != {CNT_W{1'b1}}) drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
            if ((state_r == ST_DRAIN) && drained_s) done_r <= 1'b1;
        end
    end

    assign bus.rd_valid = ~empty_s;
    assign bus.rd_pc    = rdata_s.pc;
    assign bus.rd_inst  = rdata_s.inst;
    assign bus.count    = count_s;
    assign bus.halted   = halted_r;
    assign bus.overflow = overflow_r;
    assign bus.drop_cnt = drop_cnt_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: directed scenarios plus random
// episodes, checked against a queue-based reference model.
module tb_cpu_trace_buffer;

    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    cpu_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model: mode 0 = capturing, 1 = draining, 2 = finished
    int          m_count = 0;
    int          m_mode  = 0;
    int          m_drop  = 0;
    bit          m_halted = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_done   = 1'b0;
    bit          armed    = 1'b0;
    logic [63:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // one clock: check status left by the previous edge, then drive and predict the next edge
    task automatic cycle(input bit te, input logic [31:0] p, input logic [31:0] i,
                         input bit rdy, input bit r);
        bit pop;
        bit go_drain;
        @(negedge clk);
        if (armed) begin
            chk("count",    64'(bus.count),    64'(m_count));
            chk("rd_valid", 64'(bus.rd_valid), 64'(m_count != 0));
            chk("halted",   64'(bus.halted),   64'(m_halted));
            chk("overflow", 64'(bus.overflow), 64'(m_ovf));
            chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
            chk("done",     64'(bus.done),     64'(m_done));
        end
        bus.trace_en = te;
        bus.pc       = p;
        bus.inst     = i;
        bus.rd_ready = rdy;
        rst          = r;
        if (r) begin
            m_count = 0; m_mode = 0; m_drop = 0;
            m_halted = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
            exp_q.delete();
            armed = 1'b1;
        end else begin
            pop      = rdy && (m_count > 0);
            go_drain = 1'b0;
            if (m_mode == 0 && te) begin
                if (m_count < DEPTH || pop) begin
                    exp_q.push_back({p, i});
                    m_count++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < DROP_MAX) m_drop++;
                end
                if (i == 32'h0) begin
                    m_halted = 1'b1;
                    go_drain = 1'b1;
                end
            end
            if (pop) m_count--;
            if (m_mode == 1 && m_count == 0) begin
                m_mode = 2;
                m_done = 1'b1;
            end else if (go_drain) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] i, input bit rdy);
        cycle(1'b1, p, i, rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    // monitor: every accepted pop must present the oldest expected entry
    logic [63:0] mon_e;
    always begin
        @(negedge clk);
        #2;
        if (armed && !rst) begin
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got %0h_%0h expected no entry", bus.rd_pc, bus.rd_inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("head_pc",   64'(bus.rd_pc),   64'(mon_e[63:32]));
                    chk("head_inst", 64'(bus.rd_inst), 64'(mon_e[31:0]));
                end
            end else if (!bus.rd_valid) begin
                chk("idle_data", {bus.rd_pc, bus.rd_inst}, 64'h0);
            end
        end
    end

    initial begin
        bus.trace_en = 1'b0;
        bus.pc       = 32'h0;
        bus.inst     = 32'h0;
        bus.rd_ready = 1'b0;

        // in-order capture and drain
        do_reset();
        push(32'h0040_0000, 32'h2401_0001, 1'b0);
        push(32'h0040_0004, 32'h2401_0002, 1'b0);
        push(32'h0040_0008, 32'h2401_0003, 1'b0);
        idle(1'b1, 5);

        // overflow, then push+pop while full, then drain
        do_reset();
        for (int k = 0; k < 6; k++) push(32'h0040_1000 + 32'(4 * k), 32'h1000_0000 + 32'(k + 1), 1'b0);
        push(32'h0040_2000, 32'h2000_0001, 1'b1);
        idle(1'b0, 1);
        idle(1'b1, 6);

        // halt with later trace_en pulses ignored
        do_reset();
        push(32'h0040_3000, 32'h3000_0001, 1'b0);
        push(32'h0040_3004, 32'h3000_0002, 1'b0);
        push(32'h0040_3008, 32'h0000_0000, 1'b0);
        push(32'h0040_300c, 32'h3000_0004, 1'b0);
        push(32'h0040_3010, 32'h3000_0005, 1'b0);
        idle(1'b1, 6);
        push(32'h0040_3014, 32'h3000_0006, 1'b1);

        // halt while full: halt sample dropped
        do_reset();
        for (int k = 0; k < 4; k++) push(32'h0040_4000 + 32'(4 * k), 32'h4000_0001 + 32'(k), 1'b0);
        push(32'h0040_4010, 32'h0000_0000, 1'b0);
        idle(1'b1, 7);

        // halt into an empty FIFO: capture -> drain -> done
        do_reset();
        push(32'h0040_5000, 32'h0000_0000, 1'b1);
        idle(1'b0, 3);

        // reset mid-drain with rd_ready asserted
        do_reset();
        push(32'h0040_6000, 32'h6000_0001, 1'b0);
        push(32'h0040_6004, 32'h0000_0000, 1'b0);
        idle(1'b0, 1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        idle(1'b0, 2);

        // drop counter saturation
        do_reset();
        for (int k = 0; k < 14; k++) push(32'h0040_7000 + 32'(4 * k), 32'h7000_0001 + 32'(k), 1'b0);
        idle(1'b1, 6);

        // random episodes
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                bit          te;
                bit          rdy;
                bit          r;
                logic [31:0] ins;
                te  = ($urandom_range(0, 99) < 65);
                rdy = ($urandom_range(0, 99) < ((ep % 3 == 0) ? 20 : 60));
                r   = ($urandom_range(0, 199) == 0);
                ins = ($urandom_range(0, 99) < 4) ? 32'h0 : ($urandom() | 32'h1);
                cycle(te, $urandom(), ins, rdy, r);
            end
        end

        idle(1'b1, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable retirement-trace capture buffer that sits directly downstream of `sccomp_dataflow`. It samples the CPU's `pc`/`inst` pair on every enabled clock into an on-chip FIFO and detects the halt condition (`inst == 0`), the same condition that stops the simulation clock. A host, UART bridge or bench then drains the entries over a valid/ready port. This gives a hardware-side equivalent of the per-cycle `pc`/`instr` dump, usable on the board.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, minimum 4.
- `CNT_W`, 16: width of the dropped-sample counter.
- `clk` in 1: CPU clock, the same net that drives `sccomp_dataflow.clk`.
- `rst` in 1: reset, synchronous, active-high; the same `rst` as the CPU.
- `trace_en` in 1: sample strobe; the pair is captured on a rising edge where `trace_en` = 1.
- `pc` in 32: CPU `pc` output.
- `inst` in 32: CPU `inst` output.
- `rd_ready` in 1: consumer accepts the head entry.
- `rd_valid` out 1: head entry is valid.
- `rd_pc` out 32: head entry PC.
- `rd_inst` out 32: head entry instruction.
- `count` out log2(DEPTH)+1: current occupancy.
- `halted` out 1: the halt sample has been captured.
- `overflow` out 1: sticky; at least one sample was dropped.
- `drop_cnt` out CNT_W: number of dropped samples; saturates at all-ones.
- `done` out 1: halted and FIFO drained.

## Operation
- The state machine has three states: CAPTURE → DRAIN → DONE.
- **CAPTURE**
  - A sample is accepted when `trace_en` = 1.
  - If the FIFO is not full, the pair is written at `wr_ptr` and `wr_ptr` increments.
  - If the FIFO is full, the sample is not written. `overflow` is set and `drop_cnt` increments (saturating).
  - An accepted sample with `inst == 0` is still written (if space exists). It sets `halted` and moves the FSM to DRAIN on the same edge.
  - If that halt sample is dropped because the FIFO is full, `halted` and DRAIN still take effect.
- **DRAIN**
  - All samples are ignored and `drop_cnt` is frozen.
  - Pops continue normally.
  - When `count` = 0, move to DONE.
- **DONE**
  - `done` = 1.
  - All inputs are ignored except `rst`.
  - The FSM stays in DONE until `rst`.
- **Pops**
  - A pop occurs when `rd_valid & rd_ready`, in any state.
  - `rd_valid` = (`count` ≠ 0).
  - `rd_pc` and `rd_inst` show the head entry combinationally (first-word fall-through).
  - When `rd_valid` = 0, `rd_pc` and `rd_inst` are 0.
- **Push and pop on the same edge**
  - Both take effect and `count` is unchanged.
  - When full, a simultaneous pop frees the slot, so the push is accepted rather than dropped.
  - When empty, a pop cannot occur because `rd_valid` = 0.
- **Pointers**
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is an explicit register with range 0..DEPTH.
- **Reset**
  - Reset values: FSM = CAPTURE; pointers, `count`, `drop_cnt`, `overflow`, `halted`, `done` = 0.
  - Consequently `rd_valid` = 0 after reset.
  - Memory contents are not reset.
  - A reset in any state, mid-drain included, discards all entries.
  - `rst` has priority over a push or pop on the same edge.

## Timing
- Push latency: a sample captured at edge N makes `rd_valid` = 1 in the cycle after N, if the FIFO was empty.
- Pop: the head advances at the edge where `rd_valid & rd_ready`. The next entry, or `rd_valid` = 0, is visible in the following cycle.
- `halted` rises in the cycle after the halt sample's edge.
- `done` rises in the cycle after the edge on which `count` becomes 0 in DRAIN.
  - If the FIFO is already empty when halt is captured, the path is CAPTURE → DRAIN → DONE, one edge per transition.
- Throughput: one push and one pop per cycle, sustained.
- All outputs except `rd_valid`/`rd_pc`/`rd_inst` come directly from registers.

## Structure
- A shared package `trace_pkg` holds:
  - the FSM state encoding `ST_CAPTURE`, `ST_DRAIN`, `ST_DONE`;
  - the constant `HALT_INST = 32'h0000_0000`;
  - the 64-bit entry layout {pc, inst}.
- Sub-module `trace_fifo` is a parameterized FWFT FIFO providing push, pop, full, empty and count.
- The top level holds the FSM, the halt detection and the drop counter.
- The top level is instantiated in `sccomp_dataflow_tb` alongside the existing file dump, so the bench can cross-check both traces.

## Test plan
- **Basic order:** push 3 samples (pc 0x00400000/04/08, inst 0x24010001/02/03) with `rd_ready` = 0 → `count` = 3. Then set `rd_ready` = 1 → entries pop in order, one per cycle, and `rd_valid` falls after the third.
- **Overflow:** DEPTH = 4, push 6 samples with no reads → `count` = 4, `overflow` = 1, `drop_cnt` = 2. The entries are the first 4 samples.
- **Full with simultaneous push/pop:** while full, push and pop on the same edge → push accepted, `count` stays 4, `drop_cnt` unchanged.
- **Halt:** push 2 samples, then `inst` = 0 → `halted` = 1 next cycle. Further `trace_en` pulses are ignored. Drain 3 entries, the last having `rd_inst` = 0 → `done` = 1 the cycle after the last pop.
- **Halt while full:** DEPTH = 4, full, halt sample arrives → sample dropped, `drop_cnt` +1, `halted` = 1, `done` after 4 pops.
- **Reset mid-drain:** in DRAIN with `count` = 2, assert `rst` together with `rd_ready` → next cycle `count` = 0, FSM = CAPTURE, `halted` = `overflow` = `done` = 0, `drop_cnt` = 0.
